// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-locked round-robin arbiter for a shared UART tx byte stream
// Optional stall-timeout revocation: define UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NREQ    = 3,
  parameter int MAX_PKT = 64,
  parameter int TIMEOUT = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*8-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              grant_vld,
  output logic [2:0]        grant_id,
  output logic              timeout_evt
);

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("uart_tx_arbiter: NREQ out of range");
  end
  if (MAX_PKT < 1 || MAX_PKT > 255) begin : g_bad_max_pkt
    $error("uart_tx_arbiter: MAX_PKT out of range");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("uart_tx_arbiter: TIMEOUT must be at least 1");
  end

  typedef enum logic {IDLE, LOCK} state_t;

  state_t      state, state_nxt;
  logic [2:0]  rr_ptr;
  logic [7:0]  byte_cnt;
  logic [2:0]  pick;
  logic        pick_vld;
  logic        g_valid;
  logic        g_last;
  logic [7:0]  g_data;
  logic        xfer;
  logic        cnt_hit;
  logic        release_pkt;
  logic        timeout_hit;

  // Round-robin search: first valid requester at rr_ptr, rr_ptr+1, ... wrapping at NREQ
  always_comb begin
    int idx;
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req_valid[idx]) begin
        pick     = 3'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  // Select the granted requester's lane
  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (3'(i) == grant_id) begin
        g_valid = req_valid[i];
        g_last  = req_last[i];
        g_data  = req_data[8*i +: 8];
      end
    end
  end

  assign xfer        = (state == LOCK) && g_valid && tx_ready;
  assign cnt_hit     = ({1'b0, byte_cnt} + 9'd1) == 9'(MAX_PKT);
  assign release_pkt = xfer && (g_last || cnt_hit);

`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [31:0] stall_cnt;

  assign timeout_hit = (state == LOCK) && !g_valid && (stall_cnt == 32'(TIMEOUT - 1));

  // Count consecutive cycles the grant holder has nothing to offer; pulse on revocation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt   <= '0;
      timeout_evt <= 1'b0;
    end else begin
      timeout_evt <= timeout_hit;
      if (state == IDLE || xfer) stall_cnt <= '0;
      else if (!g_valid)         stall_cnt <= stall_cnt + 32'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_evt = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: lock on any request, always drop back to IDLE for one cycle after release
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld) state_nxt = LOCK;
      LOCK:    if (release_pkt || timeout_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: combinational pass-through of the granted lane while locked
  always_comb begin
    grant_vld = (state == LOCK);
    tx_valid  = 1'b0;
    tx_data   = '0;
    req_ready = '0;
    if (state == LOCK) begin
      tx_valid = g_valid;
      tx_data  = g_data;
      for (int i = 0; i < NREQ; i++) begin
        req_ready[i] = (3'(i) == grant_id) && tx_ready;
      end
    end
  end

  // Grant owner, fairness pointer and per-grant byte count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_id <= '0;
      rr_ptr   <= '0;
      byte_cnt <= '0;
    end else begin
      if (state == IDLE && pick_vld) begin
        grant_id <= pick;
        byte_cnt <= '0;
      end else if (xfer) begin
        byte_cnt <= byte_cnt + 8'd1;
      end
      if (release_pkt || timeout_hit) begin
        rr_ptr <= (grant_id == 3'(NREQ - 1)) ? 3'd0 : grant_id + 3'd1;
      end
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter sharing one UART transmitter byte stream between NREQ requesters (echo path, status/LED reporter, debug dumper). Grants are packet-locked: once granted, a requester owns the transmitter until it sends a byte flagged last, or until MAX_PKT bytes have been sent. Sits between the requesters and the uart tx core at the toplevel. Valid/ready handshake on both sides.

Parameters:
NREQ, 3, number of requesters (2..8)
MAX_PKT, 64, maximum bytes per grant before a forced release (1..255)
TIMEOUT, 50000, stall cycles before grant revocation (optional feature only; >=1)

Ports:
clk  in  1  system clock
rst_n  in  1  reset
req_valid  in  NREQ  per-requester byte valid
req_data  in  NREQ*8  per-requester byte; requester i uses bits [8i+7:8i]
req_last  in  NREQ  byte is last of packet
req_ready  out  NREQ  per-requester accept
tx_valid  out  1  byte valid to uart tx core
tx_data  out  8  byte to uart tx core
tx_ready  in  1  uart tx core can accept byte
grant_vld  out  1  a requester currently holds the grant
grant_id  out  3  index of granted requester
timeout_evt  out  1  one-cycle pulse on grant revocation

Interface: one clock; reset is asynchronous and active-low.

Behaviour:
- States: IDLE, LOCK. Registers: state, grant_id, rr_ptr, byte_cnt (8 b), stall_cnt (optional feature only).
- Reset (async, any state, including mid-packet): state=IDLE, grant_vld=0, grant_id=0, rr_ptr=0, byte_cnt=0, timeout_evt=0. Byte on the bus is dropped; no handshake is completed.
- IDLE: tx_valid=0, all req_ready=0. If any req_valid is set, pick the first set index searching rr_ptr, rr_ptr+1, ... mod NREQ. Next edge: state=LOCK, grant_id=pick, grant_vld=1, byte_cnt=0. Latency is 1 cycle from req_valid to grant.
- LOCK, combinational pass-through: tx_valid=req_valid[g], tx_data=req_data[g], req_ready[g]=tx_ready, all other req_ready=0. A byte transfers when tx_valid && tx_ready.
- On each transfer, byte_cnt increments.
- Release: a transfer with req_last[g]=1, or a transfer that brings byte_cnt+1 to MAX_PKT. Next edge: state=IDLE, grant_vld=0, rr_ptr=(g+1) mod NREQ. grant_id holds its last value.
- After every release there is always one IDLE cycle, even when requests are pending on the same cycle as the release.
- req_valid[g] dropping mid-packet does not release the grant (unless the optional feature is enabled).
- Valid held with ready low (UART busy) is never a stall.
- Non-granted requesters are never dropped. Their valid is ignored until they are granted.
- req_last on a byte that is not transferred has no effect.

Optional Feature:
UART_TX_ARB_TIMEOUT_EN
- With the macro: in LOCK, stall_cnt increments each cycle where req_valid[g]=0, and clears on any transfer and on entry to LOCK. When stall_cnt reaches TIMEOUT-1 while still stalled, the next edge gives: state=IDLE, grant_vld=0, rr_ptr=g+1 mod NREQ, timeout_evt=1 for exactly one cycle.
- Without the macro: no stall_cnt, timeout_evt is tied to 0, and the grant is held indefinitely.

Test Plan:
1. NREQ=3. Req1 alone sends a 4-byte packet 0x41..0x44 with last on 0x44, tx_ready=1 -> grant_id=1 one cycle after valid; 4 bytes appear in order; grant_vld=0 the cycle after 0x44; rr_ptr=2.
2. All three requesters continuously valid with 2-byte packets -> grant order 0,1,2,0; exactly one IDLE cycle between packets; no byte from a non-granted requester reaches tx_data.
3. MAX_PKT=4. Req0 streams 10 bytes with no last -> release after byte 4; req1 (pending) granted next; req0 resumes byte 5 in its following grant.
4. tx_ready toggled 1 cycle high, 9 cycles low during the packet -> bytes transfer only on high cycles; data stays stable while valid and not ready; no duplicate or lost bytes.
5. rst_n pulsed low mid-packet after byte 2 of 5 -> grant_vld=0 and tx_valid=0 immediately (async); after release, arbitration restarts at index 0.
6. With UART_TX_ARB_TIMEOUT_EN and TIMEOUT=8, req2 drops valid after 1 byte -> timeout_evt pulses once 8 stall cycles later; req0 is granted after the IDLE cycle. Without the macro -> grant is held for 1000 cycles and timeout_evt stays 0.
